// File: rtl/digit_sequencer.sv
// Converts an 8-bit value to BCD by sequential double-dabble, then cycles the
// significant decimal digits plus a blank slot onto a 4-bit digit bus.
module digit_sequencer #(
  parameter  int HOLD_CYCLES = 10_000_000,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value_in,
  input  logic       load_in,
  output logic       busy_out,
  output logic [3:0] digit_out,
  output logic [1:0] slot_out
);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]       BLANK    = 4'hF;
  localparam logic [1:0]       SLOT_BLK = 2'd3;

  state_t           state, state_n;
  logic [7:0]       bin, bin_n;
  logic [11:0]      bcd, bcd_n;
  logic [2:0]       iter, iter_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       slot, slot_n;
  logic [3:0]       digit, digit_n;
  logic [19:0]      shifted;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int unsigned i = 0; i < 3; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Leading-zero suppression: the list starts at the first nonzero digit,
  // and the ones digit is always shown.
  function automatic logic [1:0] first_slot(input logic [11:0] b);
    if (b[11:8] != 4'd0)     return 2'd0;
    else if (b[7:4] != 4'd0) return 2'd1;
    else                     return 2'd2;
  endfunction

  function automatic logic [3:0] slot_digit(input logic [11:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return b[11:8];
      2'd1:    return b[7:4];
      2'd2:    return b[3:0];
      default: return BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      iter  <= '0;
      cnt   <= '0;
      slot  <= SLOT_BLK;
      digit <= BLANK;
    end else begin
      state <= state_n;
      bin   <= bin_n;
      bcd   <= bcd_n;
      iter  <= iter_n;
      cnt   <= cnt_n;
      slot  <= slot_n;
      digit <= digit_n;
    end
  end

  always_comb begin
    state_n = state;
    bin_n   = bin;
    bcd_n   = bcd;
    iter_n  = iter;
    cnt_n   = cnt;
    slot_n  = slot;
    digit_n = digit;
    shifted = {add3(bcd), bin} << 1;

    // A load outside CONVERT takes priority over any slot advance.
    if (load_in && state != CONVERT) begin
      state_n = CONVERT;
      bin_n   = value_in;
      bcd_n   = '0;
      iter_n  = '0;
      cnt_n   = '0;
      slot_n  = SLOT_BLK;
      digit_n = BLANK;
    end else begin
      case (state)
        CONVERT: begin
          {bcd_n, bin_n} = shifted;
          iter_n         = iter + 3'd1;
          if (iter == 3'd7) begin
            state_n = SHOW;
            cnt_n   = '0;
            slot_n  = first_slot(shifted[19:8]);
            digit_n = slot_digit(shifted[19:8], slot_n);
          end
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            slot_n  = (slot == SLOT_BLK) ? first_slot(bcd) : slot + 2'd1;
            digit_n = slot_digit(bcd, slot_n);
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_out  = (state == CONVERT);
  assign digit_out = digit;
  assign slot_out  = slot;

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench for digit_sequencer: per-cycle expectations are queued from a
// decimal model and compared one entry per clock against the DUT outputs.
module tb_digit_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value_a = '0, value_b = '0;
  logic       load_a = 1'b0, load_b = 1'b0;
  logic       busy_a, busy_b;
  logic [3:0] digit_a, digit_b;
  logic [1:0] slot_a, slot_b;

  int checks = 0;
  int failures = 0;
  int sel = 0;             // 0: DUT with HOLD_CYCLES=3, 1: DUT with HOLD_CYCLES=2
  logic [6:0] expq[$];     // {digit, slot, busy}

  always #5 clk = ~clk;

  digit_sequencer #(.HOLD_CYCLES(3)) u_h3 (
    .clk(clk), .rst_n(rst_n), .value_in(value_a), .load_in(load_a),
    .busy_out(busy_a), .digit_out(digit_a), .slot_out(slot_a)
  );

  digit_sequencer #(.HOLD_CYCLES(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .value_in(value_b), .load_in(load_b),
    .busy_out(busy_b), .digit_out(digit_b), .slot_out(slot_b)
  );

  function automatic logic [6:0] observed();
    return (sel == 1) ? {digit_b, slot_b, busy_b} : {digit_a, slot_a, busy_a};
  endfunction

  task automatic cmp(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed digit=%h slot=%0d busy=%b expected digit=%h slot=%0d busy=%b",
             tag, obs[6:3], obs[2:1], obs[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic push_n(input logic [3:0] d, input logic [1:0] s, input logic b, input int n);
    for (int i = 0; i < n; i++) expq.push_back({d, s, b});
  endtask

  task automatic push_show(input int v, input int hold, input int rounds);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    for (int r = 0; r < rounds; r++) begin
      if (h != 0) push_n(4'(h), 2'd0, 1'b0, hold);
      if (h != 0 || t != 0) push_n(4'(t), 2'd1, 1'b0, hold);
      push_n(4'(o), 2'd2, 1'b0, hold);
      push_n(4'hF, 2'd3, 1'b0, hold);
    end
  endtask

  // One compare per clock, sampled 1 time unit after the rising edge.
  // Load strobes are dropped and value_in is scrambled after each edge.
  task automatic run(input string tag, input int n);
    logic [6:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      load_a  = 1'b0;
      load_b  = 1'b0;
      value_a = 8'($urandom);
      value_b = 8'($urandom);
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s observed=empty-queue expected=entry", tag);
      end else begin
        e = expq.pop_front();
        cmp(tag, observed(), e);
      end
    end
  endtask

  task automatic drive_load(input logic [7:0] v);
    @(negedge clk);
    if (sel == 1) begin value_b = v; load_b = 1'b1; end
    else          begin value_a = v; load_a = 1'b1; end
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    cmp(tag, observed(), {4'hF, 2'd3, 1'b0});
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with no load
    sel = 0;
    push_n(4'hF, 2'd3, 1'b0, 20);
    run("reset_hold", 20);
    @(negedge clk);
    rst_n = 1'b1;
    push_n(4'hF, 2'd3, 1'b0, 3);
    run("idle_after_reset", 3);

    // 205 with HOLD_CYCLES=3, two full rounds
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_show(205, 3, 2);
    drive_load(8'd205);
    run("v205", expq.size());

    // 255, then a load of 99 mid-conversion must be ignored
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_show(255, 3, 1);
    drive_load(8'd255);
    run("v255_conv", 4);
    drive_load(8'd99);
    run("v255_ignore99", expq.size());

    // 123, reload with 88 exactly on the first slot-advance edge
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_n(4'd1, 2'd0, 1'b0, 3);
    drive_load(8'd123);
    run("v123", expq.size());
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_show(88, 3, 2);
    drive_load(8'd88);
    run("v88_on_advance", expq.size());

    // HOLD_CYCLES=2 instance: 7, 40, 0
    sel = 1;
    push_n(4'hF, 2'd3, 1'b0, 2);
    run("h2_idle", 2);
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_show(7, 2, 2);
    drive_load(8'd7);
    run("v7", expq.size());
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_show(40, 2, 2);
    drive_load(8'd40);
    run("v40", expq.size());
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_show(0, 2, 2);
    drive_load(8'd0);
    run("v0", expq.size());

    // Asynchronous reset mid-CONVERT and mid-SHOW
    sel = 0;
    push_n(4'hF, 2'd3, 1'b1, 3);
    drive_load(8'd10);
    run("pre_rst_conv", 3);
    async_reset_check("async_rst_convert");
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_n(4'd1, 2'd1, 1'b0, 2);
    drive_load(8'd123 - 8'd113);
    run("pre_rst_show", expq.size());
    async_reset_check("async_rst_show");
    push_n(4'hF, 2'd3, 1'b0, 2);
    run("idle_after_async", 2);
    push_n(4'hF, 2'd3, 1'b1, 8);
    push_show(10, 3, 2);
    drive_load(8'd10);
    run("v10_after_reset", expq.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
